// File: rtl/uart_pkg.sv
// uart_pkg: shared byte type, arbiter state encoding and source limit for UART transmit sharing
package uart_pkg;
  localparam int NUM_SRC_MAX = 8;
  typedef logic [7:0] byte_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick (req, ptr -> onehot, idx, valid), nearest requester after ptr wins
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] k;
  always_comb begin
    onehot = '0;
    idx = '0;
    valid = 1'b0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = W'((int'(ptr) + i) % N);
      if (req[k]) begin
        valid = 1'b1;
        idx = k;
        onehot = '0;
        onehot[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-locked round-robin sharing of one UART TX (Req/Data/Last in, XMitGo/TxData/Ack/Grant/Busy/Error out)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_SRC-1:0]     Req,
  input  logic [8*NUM_SRC-1:0]   Data,
  input  logic [NUM_SRC-1:0]     Last,
  input  logic                   TxEmpty,
  output logic                   XMitGo,
  output logic [7:0]             TxData,
  output logic [NUM_SRC-1:0]     Ack,
  output logic [NUM_SRC-1:0]     Grant,
  output logic                   Busy,
  output logic                   Error
);
  localparam int PW = $clog2(NUM_SRC);
  localparam int WW = $clog2(TIMEOUT + 1);
  arb_state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [WW-1:0] wd_q, wd_d;
  logic [NUM_SRC-1:0] grant_q, grant_d, ack_q, ack_d, pick_oh;
  logic last_q, last_d, xmit_go_q, xmit_go_d, busy_q, busy_d, error_q, error_d, pick_valid;
  byte_t tx_data_q, tx_data_d;
  byte_t src_data [NUM_SRC];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_data[i] = Data[8*i +: 8];
  end
  rr_picker #(.N(NUM_SRC), .W(PW)) u_pick (
    .req    (Req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    wd_d = wd_q;
    grant_d = grant_q;
    ack_d = '0;
    last_d = last_q;
    tx_data_d = tx_data_q;
    busy_d = busy_q;
    error_d = 1'b0;
    case (state_q)
      IDLE: if (pick_valid && TxEmpty) begin
        state_d = SEND;
        grant_d = pick_oh;
        idx_d = pick_idx;
        tx_data_d = src_data[pick_idx];
        last_d = Last[pick_idx];
        busy_d = 1'b1;
        wd_d = '0;
      end
      SEND: if (!TxEmpty) begin
        state_d = DONE;
      end else if (wd_q == WW'(TIMEOUT - 1)) begin
        // the stuck byte is acked so its source moves on instead of retrying forever
        state_d = IDLE;
        error_d = 1'b1;
        ack_d = grant_q;
        grant_d = '0;
        busy_d = 1'b0;
        ptr_d = idx_q;
      end else begin
        wd_d = wd_q + WW'(1);
      end
      DONE: begin
        ack_d = grant_q;
        state_d = last_q ? IDLE : HOLD;
        grant_d = last_q ? '0 : grant_q;
        busy_d = !last_q;
        ptr_d = last_q ? idx_q : ptr_q;
      end
      HOLD: if (!Req[idx_q]) begin
        state_d = IDLE;
        grant_d = '0;
        busy_d = 1'b0;
        ptr_d = idx_q;
      end else if (TxEmpty) begin
        state_d = SEND;
        tx_data_d = src_data[idx_q];
        last_d = Last[idx_q];
        wd_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d = 1'b0;
        tx_data_d = '0;
        wd_d = '0;
      end
    endcase
    // XMitGo stays up through DONE so it drops together with the Ack pulse
    xmit_go_d = (state_d == SEND) || (state_d == DONE);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q <= PW'(NUM_SRC - 1);
      idx_q <= '0;
      wd_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      last_q <= 1'b0;
      tx_data_q <= '0;
      xmit_go_q <= 1'b0;
      busy_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      wd_q <= wd_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      last_q <= last_d;
      tx_data_q <= tx_data_d;
      xmit_go_q <= xmit_go_d;
      busy_q <= busy_d;
      error_q <= error_d;
    end
  end
  assign XMitGo = xmit_go_q;
  assign TxData = tx_data_q;
  assign Ack = ack_q;
  assign Grant = grant_q;
  assign Busy = busy_q;
  assign Error = error_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized traffic against a message-queue reference model plus directed corner cases
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 20;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [N-1:0] Req = '0;
  logic [N-1:0] Last = '0;
  logic [8*N-1:0] Data = '0;
  logic TxEmpty = 1'b1;
  logic XMitGo, Busy, Error;
  logic [7:0] TxData;
  logic [N-1:0] Ack, Grant;
  int tests = 0;
  int fails = 0;
  logic [8:0] srcq [N][$];
  logic [7:0] sent[$];
  logic [7:0] exp_log[$];
  int owner = -1;
  int mptr = N - 1;
  int ack_wait = -1;
  int uart_cnt = 0;
  uart_tx_arbiter #(.NUM_SRC(N), .TIMEOUT(TO)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Data    (Data),
    .Last    (Last),
    .TxEmpty (TxEmpty),
    .XMitGo  (XMitGo),
    .TxData  (TxData),
    .Ack     (Ack),
    .Grant   (Grant),
    .Busy    (Busy),
    .Error   (Error)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  function automatic logic [N-1:0] oh(input int i);
    return (i < 0) ? '0 : N'(1) << i;
  endfunction
  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++)
      if (r[2'((p + i) % N)]) return (p + i) % N;
    return -1;
  endfunction
  function automatic logic model_busy();
    logic b;
    b = (owner >= 0) || (ack_wait >= 0);
    for (int i = 0; i < N; i++) b = b || (srcq[i].size() != 0);
    return b;
  endfunction
  task automatic push_byte(input int s, input logic [7:0] b, input logic l);
    srcq[s].push_back({l, b});
  endtask
  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      Req[i] = srcq[i].size() != 0;
      Data[8*i +: 8] = 8'h00;
      Last[i] = 1'b0;
      if (Req[i]) begin
        Data[8*i +: 8] = srcq[i][0][7:0];
        Last[i] = srcq[i][0][8];
      end
    end
  endtask
  task automatic check_log(input string tag);
    check({tag, "_len"}, sent.size(), exp_log.size());
    for (int i = 0; i < sent.size() && i < exp_log.size(); i++) check(tag, sent[i], exp_log[i]);
    sent.delete();
    exp_log.delete();
  endtask
  task automatic run_model(input int budget);
    int n;
    logic [8:0] h;
    n = 0;
    while (model_busy() && n < budget) begin
      step();
      n++;
      if (owner < 0 && Req != 0 && TxEmpty) begin
        owner = rr(Req, mptr);
        check("start_xmit", XMitGo, 1);
        check("start_txdata", TxData, srcq[owner][0][7:0]);
      end
      if (ack_wait > 0) ack_wait--;
      check("ack", Ack, ack_wait == 0 ? oh(owner) : '0);
      if (ack_wait == 0) begin
        check("xmit_at_ack", XMitGo, 0);
        h = srcq[owner].pop_front();
        if (h[8]) begin
          mptr = owner;
          owner = -1;
        end
        ack_wait = -1;
      end
      check("grant", Grant, oh(owner));
      check("busy", Busy, owner >= 0);
      check("error", Error, 0);
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) TxEmpty = 1'b1;
      end else if (TxEmpty && XMitGo && ack_wait < 0 && owner >= 0 && $urandom_range(3, 0) != 0) begin
        check("accept_txdata", TxData, srcq[owner][0][7:0]);
        sent.push_back(TxData);
        TxEmpty = 1'b0;
        uart_cnt = $urandom_range(3, 1);
        ack_wait = 2;
      end
      drive_srcs();
    end
    check("drain_in_budget", n < budget, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end
  initial begin
    int n, len;
    Reset = 1'b1;
    Req = '1;
    Last = '1;
    Data = 32'hdeadbeef;
    TxEmpty = 1'b1;
    repeat (2) begin
      step();
      check("rst_xmit", XMitGo, 0);
      check("rst_txdata", TxData, 0);
      check("rst_ack", Ack, 0);
      check("rst_grant", Grant, 0);
      check("rst_busy", Busy, 0);
      check("rst_error", Error, 0);
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_byte(0, 8'h41, 1'b1);
      exp_log.push_back(8'h41);
      if (i < 3) begin
        push_byte(2, 8'h42, 1'b1);
        exp_log.push_back(8'h42);
      end
    end
    drive_srcs();
    run_model(500);
    check_log("fair");
    push_byte(1, 8'h48, 1'b0);
    push_byte(1, 8'h69, 1'b0);
    push_byte(1, 8'h0A, 1'b1);
    push_byte(3, 8'h33, 1'b1);
    exp_log.push_back(8'h48);
    exp_log.push_back(8'h69);
    exp_log.push_back(8'h0A);
    exp_log.push_back(8'h33);
    drive_srcs();
    run_model(500);
    check_log("lock");
    for (int s = 0; s < N; s++)
      for (int m = 0; m < 3; m++) begin
        len = $urandom_range(3, 1);
        for (int b = 0; b < len; b++) push_byte(s, 8'($urandom), b == len - 1);
      end
    drive_srcs();
    run_model(3000);
    sent.delete();
    TxEmpty = 1'b1;
    uart_cnt = 0;
    step();
    Req = 4'b0100;
    Data = '0;
    Data[23:16] = 8'h5A;
    Last = 4'b0100;
    step();
    check("to_grant", Grant, 4'b0100);
    check("to_xmit", XMitGo, 1);
    check("to_txdata", TxData, 8'h5A);
    n = 0;
    while (!Error && n < 100) begin
      step();
      n++;
    end
    check("to_cycles", n, TO);
    check("to_ack", Ack, 4'b0100);
    check("to_xmit_low", XMitGo, 0);
    check("to_grant_clr", Grant, 0);
    check("to_busy_clr", Busy, 0);
    Req = '0;
    Last = '0;
    step();
    check("to_err_once", Error, 0);
    check("to_ack_once", Ack, 0);
    Req = 4'b0011;
    Data[7:0] = 8'h11;
    Data[15:8] = 8'h22;
    Last = 4'b0010;
    step();
    check("ab_grant", Grant, 4'b0001);
    check("ab_txdata", TxData, 8'h11);
    TxEmpty = 1'b0;
    step();
    check("ab_ack_wait", Ack, 0);
    TxEmpty = 1'b1;
    step();
    check("ab_ack", Ack, 4'b0001);
    check("ab_hold_grant", Grant, 4'b0001);
    Req = 4'b0010;
    step();
    check("ab_release", Grant, 0);
    check("ab_no_ack", Ack, 0);
    step();
    check("ab_next_grant", Grant, 4'b0010);
    check("ab_next_data", TxData, 8'h22);
    check("ab_next_no_ack", Ack, 0);
    TxEmpty = 1'b0;
    step();
    TxEmpty = 1'b1;
    step();
    check("ab_ack1", Ack, 4'b0010);
    Req = '0;
    Last = '0;
    step();
    check("ab_idle", Grant, 0);
    Req = 4'b1001;
    Data[31:24] = 8'h77;
    Data[7:0] = 8'h10;
    Last = 4'b1001;
    step();
    check("rm_grant", Grant, 4'b1000);
    check("rm_xmit", XMitGo, 1);
    Reset = 1'b1;
    step();
    check("rm_xmit_low", XMitGo, 0);
    check("rm_no_ack", Ack, 0);
    check("rm_grant_clr", Grant, 0);
    check("rm_busy_clr", Busy, 0);
    Reset = 1'b0;
    step();
    check("rm_ptr_reset", Grant, 4'b0001);
    check("rm_no_ack2", Ack, 0);
    Req = '0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
